// File: rtl/uart_pkg.sv
// Shared UART definitions used by the transmit framer and the receiver.
// UART_TX_PARITY_EN adds the parity state and the 11-bit frame length.
package uart_pkg;

    localparam int UART_DATA_BITS = 8;
    localparam int UART_FRAME_BITS_PARITY = 11;
    localparam int UART_FRAME_BITS_PLAIN = 10;

`ifdef UART_TX_PARITY_EN
    localparam int UART_FRAME_BITS = UART_FRAME_BITS_PARITY;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_e;
`else
    localparam int UART_FRAME_BITS = UART_FRAME_BITS_PLAIN;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_e;
`endif

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1, wraps, and flags the bit end.
// pre_tick marks the cycle before the last one so callers can register pulses.
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic clk,
    input  logic n_rst,
    input  logic clear,
    output logic tick,
    output logic pre_tick
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] PRE = CW'(CLKS_PER_BIT - 2);

    if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535) begin : g_bad_cpb
        $error("uart_baud_tick: CLKS_PER_BIT out of range");
    end

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count <= '0;
        end else if (clear || count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign tick = (count == LAST);
    assign pre_tick = (count == PRE);

endmodule

// File: rtl/uart_tx_framer.sv
// UART transmit framer: start, 8 data bits LSB first, optional parity, stop.
// Define UART_TX_PARITY_EN for the 11-bit frame with a parity bit.
module uart_tx_framer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 5208,
    parameter int PARITY_ODD = 0
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx,
    output logic       busy,
    output logic       frame_done
);

    if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_par
        $error("uart_tx_framer: PARITY_ODD must be 0 or 1");
    end

    uart_state_e state;
    logic [UART_DATA_BITS-1:0] shift;
    logic [2:0] index;
    logic bit_end;
    logic bit_pre;
    logic handshake;
`ifdef UART_TX_PARITY_EN
    logic parity;
`endif

    assign tx_ready = (state == IDLE);
    assign busy = ~tx_ready;
    assign handshake = tx_valid && tx_ready;

    // Timer is held at zero while idle so START gets a full bit period.
    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_tick (
        .clk     (clk),
        .n_rst   (n_rst),
        .clear   (tx_ready),
        .tick    (bit_end),
        .pre_tick(bit_pre)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
            shift <= '0;
            index <= '0;
            tx <= 1'b1;
            frame_done <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity <= 1'b0;
`endif
        end else begin
            frame_done <= (state == STOP) && bit_pre;
            unique case (state)
                IDLE: begin
                    if (handshake) begin
                        shift <= tx_data;
`ifdef UART_TX_PARITY_EN
                        parity <= (^tx_data) ^ 1'(PARITY_ODD);
`endif
                        index <= '0;
                        tx <= 1'b0;
                        state <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        tx <= shift[0];
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (index == 3'd7) begin
                            index <= '0;
`ifdef UART_TX_PARITY_EN
                            tx <= parity;
                            state <= PARITY;
`else
                            tx <= 1'b1;
                            state <= STOP;
`endif
                        end else begin
                            tx <= shift[1];
                            shift <= shift >> 1;
                            index <= index + 3'd1;
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        tx <= 1'b1;
                        state <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (bit_end) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    tx <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_framer.sv
// Bench for uart_tx_framer: vector table, serial scoreboard, corner sequences.
// Frame length follows UART_TX_PARITY_EN.
`timescale 1ns/1ps
module tb_uart_tx_framer;

    localparam int C = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic clk = 1'b0;
    logic n_rst;
    logic [7:0] tx_data;
    logic tx_valid;
    logic tx_ready, tx, busy, frame_done;
    logic [7:0] odd_data;
    logic odd_valid;
    logic odd_ready, odd_tx, odd_busy, odd_done;

    always #5 clk = ~clk;

    uart_tx_framer #(
        .CLKS_PER_BIT(C),
        .PARITY_ODD(0)
    ) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .tx        (tx),
        .busy      (busy),
        .frame_done(frame_done)
    );

    uart_tx_framer #(
        .CLKS_PER_BIT(C),
        .PARITY_ODD(1)
    ) dut_odd (
        .clk       (clk),
        .n_rst     (n_rst),
        .tx_data   (odd_data),
        .tx_valid  (odd_valid),
        .tx_ready  (odd_ready),
        .tx        (odd_tx),
        .busy      (odd_busy),
        .frame_done(odd_done)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    logic [10:0] exp_q[$];
    int hs_q[$];
    bit mon_busy = 1'b0;
    int last_start = 0;
    int prev_start = 0;

    typedef struct {
        logic [7:0] data;
        logic       par;
    } vec_t;
    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Independent frame model: bit 0 is the start bit, data LSB first.
    function automatic logic [10:0] frame_of(input logic [7:0] d,
                                             input logic p);
        logic [10:0] f;
        f = '0;
        f[8:1] = d;
`ifdef UART_TX_PARITY_EN
        f[9] = p;
        f[10] = 1'b1;
`else
        f[9] = 1'b1;
`endif
        return f;
    endfunction

    task automatic expect_frame(input logic [7:0] d, input logic p);
        exp_q.push_back(frame_of(d, p));
        hs_q.push_back(cyc);
    endtask

    // Called at the negedge of the first start cycle; samples every cycle.
    task automatic capture(input bit sel, output logic [10:0] f,
                           output int glitch, output int ctl,
                           output bit aborted);
        logic v, d, r, b;
        f = '0;
        glitch = 0;
        ctl = 0;
        aborted = 1'b0;
        for (int i = 0; i < NB; i++) begin
            for (int c = 0; c < C; c++) begin
                if (i != 0 || c != 0) @(negedge clk);
                if (n_rst !== 1'b1) begin
                    aborted = 1'b1;
                    return;
                end
                v = sel ? odd_tx : tx;
                d = sel ? odd_done : frame_done;
                r = sel ? odd_ready : tx_ready;
                b = sel ? odd_busy : busy;
                if (c == 0) f[i] = v;
                else if (v !== f[i]) glitch++;
                if (d !== (i == NB - 1 && c == C - 1)) ctl++;
                if (r !== 1'b0 || b !== 1'b1) ctl++;
            end
        end
    endtask

    initial begin : monitor
        logic [10:0] f;
        int g, k, st;
        bit ab;
        forever begin
            @(negedge clk);
            if (n_rst === 1'b1 && tx === 1'b0) begin
                mon_busy = 1'b1;
                st = cyc;
                capture(1'b0, f, g, k, ab);
                if (!ab) begin
                    chk("frame_expected", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        chk("frame_bits", f, exp_q.pop_front());
                        chk("start_latency", st - hs_q.pop_front(), 1);
                    end
                    chk("bit_glitch", g, 0);
                    chk("frame_ctl", k, 0);
                    prev_start = last_start;
                    last_start = st;
                    @(negedge clk);
                    chk("ready_after", {tx_ready, busy, tx, frame_done},
                        4'b1010);
                end
                mon_busy = 1'b0;
            end
        end
    end

    task automatic send(input logic [7:0] d, input logic p, input bit hold);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (tx_ready !== 1'b1 && n < 200);
        if (tx_ready !== 1'b1) begin
            chk("ready_timeout", tx_ready, 1);
            return;
        end
        tx_data = d;
        tx_valid = 1'b1;
        expect_frame(d, p);
        @(posedge clk);
        #1;
        if (!hold) tx_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || mon_busy) && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("drain", exp_q.size() == 0 && !mon_busy, 1);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : main
        logic [10:0] f;
        int g, k, n;
        bit ab;

        vecs[0] = '{8'h55, 1'b0};
        vecs[1] = '{8'h81, 1'b0};
        vecs[2] = '{8'h00, 1'b0};
        vecs[3] = '{8'hFF, 1'b0};
        vecs[4] = '{8'h01, 1'b1};
        vecs[5] = '{8'h7F, 1'b1};
        vecs[6] = '{8'hA5, 1'b0};
        vecs[7] = '{8'hE0, 1'b1};

        n_rst = 1'b0;
        tx_valid = 1'b0;
        tx_data = 8'h00;
        odd_valid = 1'b0;
        odd_data = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_tx", tx, 1);
        chk("rst_ready", tx_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_odd_tx", odd_tx, 1);
        n_rst = 1'b1;

        foreach (vecs[i]) begin
            send(vecs[i].data, vecs[i].par, 1'b0);
            wait_idle();
        end

        // Back-to-back frames with tx_valid held high.
        send(8'h00, 1'b0, 1'b1);
        send(8'hFF, 1'b0, 1'b0);
        wait_idle();
        chk("b2b_spacing", last_start - prev_start, NB * C + 1);

        // Input changes after the handshake must not leak into the frame.
        send(8'h96, 1'b0, 1'b0);
        repeat (12) @(negedge clk);
        tx_data = 8'h69;
        wait_idle();

        // Odd-parity instance.
        @(negedge clk);
        odd_data = 8'hA5;
        odd_valid = 1'b1;
        @(posedge clk);
        #1;
        odd_valid = 1'b0;
        odd_data = 8'h00;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (odd_tx !== 1'b0 && n < 10);
        chk("odd_start_latency", n, 1);
        if (odd_tx === 1'b0) begin
            capture(1'b1, f, g, k, ab);
            chk("odd_frame", f, frame_of(8'hA5, 1'b1));
            chk("odd_glitch", g, 0);
            chk("odd_ctl", k, 0);
        end

        // Asynchronous reset in the middle of a frame.
        send(8'hC3, 1'b0, 1'b0);
        repeat (17) @(negedge clk);
        n_rst = 1'b0;
        #1;
        chk("midrst_tx", tx, 1);
        chk("midrst_ready", tx_ready, 1);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", frame_done, 0);
        repeat (2) @(negedge clk);
        exp_q.delete();
        hs_q.delete();
        // Handshake on the very first edge after reset release.
        n_rst = 1'b1;
        tx_data = 8'h3C;
        tx_valid = 1'b1;
        expect_frame(8'h3C, 1'b0);
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        wait_idle();

        chk("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
